ccip_wr_engine: RTL and testbench
=================================

CCIP_WR_ENGINE -- requirements
Module: ccip_wr_engine

Interface
REQ-001 SHALL have clk  input  1  clock; all logic rising-edge.
REQ-002 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have start  input  1  one-cycle request to begin a write burst.
REQ-004 SHALL have base_cl_addr  input  42  cache-line address of first line (t_ccip_clAddr).
REQ-005 SHALL have num_lines  input  16  lines to write; sampled with start.
REQ-006 SHALL have seed  input  64  data seed; sampled with start.
REQ-007 SHALL have rx  input  t_if_ccip_Rx  uses c1TxAlmFull and c1 response channel only.
REQ-008 SHALL have tx_c1  output  t_if_ccip_c1_Tx  write-request channel.
REQ-009 SHALL have busy  output  1  high from accepted start until done.
REQ-010 SHALL have done  output  1  one-cycle pulse when all responses received.
REQ-011 SHALL have acked  output  16  write responses counted in current burst.

Function
REQ-012 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-013 IDLE: start=1 -> latch base_cl_addr, num_lines, seed; clear issue index and acked; go ISSUE (num_lines=0 -> go DONE directly).
REQ-014 start SHALL be ignored in any state other than IDLE.
REQ-015 ISSUE: each cycle rx.c1TxAlmFull=0, register tx_c1.valid=1 for line i; rx.c1TxAlmFull=1 -> tx_c1.valid=0 next cycle, index held.
REQ-016 Request header SHALL be: vc_sel eVC_VA, sop 1, mode eMOD_CL, cl_len eCL_LEN_1, req_type eREQ_WRLINE_I, address base+i (42-bit wrap), mdata = i[15:0].
REQ-017 Line i data SHALL be eight 64-bit words, word k = seed + i*8 + k (mod 2^64), word 0 in bits 63:0.
REQ-018 After issuing line num_lines-1, SHALL move to DRAIN; tx_c1.valid deasserts the following cycle.
REQ-019 acked SHALL increment by 1 for each cycle rx.c1.rspValid=1 with resp_type eRSP_WRLINE and format=0, in ISSUE or DRAIN; other responses ignored.
REQ-020 format=1 (packed) responses SHALL increment acked by cl_num+1.
REQ-021 DRAIN: acked = num_lines -> DONE; DONE asserts done for exactly one cycle then returns to IDLE.
REQ-022 Response arriving same cycle as final issue SHALL be counted; no response lost on simultaneous events.
REQ-023 Responses arriving in IDLE SHALL be ignored; acked holds last burst value until next start.
REQ-024 busy SHALL be 1 in ISSUE, DRAIN, DONE; 0 in IDLE.
REQ-025 Outputs SHALL be registered; no combinational path rx -> tx_c1.

Reset
REQ-026 Reset SHALL force IDLE, tx_c1.valid=0, tx_c1.hdr=0, tx_c1.data=0, busy=0, done=0, acked=0, index=0.
REQ-027 Reset mid-burst SHALL abandon the burst immediately; outstanding responses after release are ignored (IDLE).

Structure
REQ-028 State enum and mdata width constant SHALL live in shared package afu_pkg; CCI-P types from ccip_if_pkg.
REQ-029 Line-data generator SHALL be a sub-module ccip_line_gen (seed, index -> 512-bit line), combinational.
REQ-030 MMIO block SHALL drive start/base_cl_addr/num_lines/seed from its registers.

Verification
REQ-031 base=0x1000, num_lines=4, seed=0, alm_full=0 -> 4 consecutive valids, addr 0x1000..0x1003, mdata 0..3, line 1 word 0 = 8; 4 responses -> done pulse, acked=4.
REQ-032 num_lines=3, alm_full high cycles 2-4 after start -> no valid those cycles; all 3 lines issued in order afterwards, no duplicates.
REQ-033 num_lines=0 -> no valid, done pulses 2 cycles after start, acked=0.
REQ-034 num_lines=4, one packed response cl_num=1 plus two single -> acked=4, done once.
REQ-035 start re-asserted during ISSUE -> ignored; burst parameters unchanged.
REQ-036 rst asserted after 2 of 8 lines -> valid=0, busy=0 immediately; later responses leave acked=0.

Source files
------------

// File: rtl/afu_pkg.sv
// Shared AFU constants and the write-engine state encoding.
package afu_pkg;

    localparam int MDATA_W    = 16;
    localparam int LINE_WORDS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } t_wr_state;

endpackage

// File: rtl/ccip_if_pkg.sv
// Minimal CCI-P channel types used by the AFU write path.
// Field layout follows the CCI-P c1 request/response headers.
package ccip_if_pkg;

    typedef logic [41:0]  t_ccip_clAddr;
    typedef logic [15:0]  t_ccip_mdata;
    typedef logic [511:0] t_ccip_clData;
    typedef logic [1:0]   t_ccip_clNum;

    typedef enum logic [1:0] {
        eVC_VA  = 2'd0,
        eVC_VL0 = 2'd1,
        eVC_VH0 = 2'd2,
        eVC_VH1 = 2'd3
    } t_ccip_vc;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'd0,
        eCL_LEN_2 = 2'd1,
        eCL_LEN_4 = 2'd3
    } t_ccip_clLen;

    typedef enum logic {
        eMOD_CL   = 1'b0,
        eMOD_BYTE = 1'b1
    } t_ccip_c1_mode;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4,
        eREQ_INTR     = 4'h6
    } t_ccip_c1_req;

    typedef enum logic [3:0] {
        eRSP_WRLINE  = 4'h0,
        eRSP_WRFENCE = 4'h4,
        eRSP_INTR    = 4'h6
    } t_ccip_c1_rsp;

    typedef struct packed {
        logic [5:0]    rsvd2;
        t_ccip_vc      vc_sel;
        logic          sop;
        t_ccip_c1_mode mode;
        t_ccip_clLen   cl_len;
        t_ccip_c1_req  req_type;
        logic [5:0]    rsvd0;
        t_ccip_clAddr  address;
        t_ccip_mdata   mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic         format;
        logic         rsvd0;
        t_ccip_clNum  cl_num;
        t_ccip_c1_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c1_RspMemHdr;

    typedef struct packed {
        logic [27:0]  hdr;
        t_ccip_clData data;
        logic         rspValid;
        logic         mmioRdValid;
        logic         mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_c1_RspMemHdr hdr;
        logic               rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        t_ccip_clData       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

endpackage

// File: rtl/ccip_line_gen.sv
// Combinational generator of the 512-bit test pattern for one cache line:
// word k of line i is seed + 8*i + k, word 0 in the low bits.
module ccip_line_gen
    import ccip_if_pkg::*;
    import afu_pkg::*;
(
    input  logic [63:0]        seed,
    input  logic [MDATA_W-1:0] index,
    output t_ccip_clData       line
);

    logic [63:0] base_s;

    assign base_s = seed + {{(64 - MDATA_W - 3){1'b0}}, index, 3'b000};

    // Consecutive words counting up from the line base, modulo 2^64
    always_comb begin
        line = '0;
        for (int k = 0; k < LINE_WORDS; k++) begin
            line[k*64 +: 64] = base_s + 64'(k);
        end
    end

endmodule

// File: rtl/ccip_wr_engine.sv
// CCI-P write-burst engine: issues num_lines WrLine_I requests with generated
// data, honouring c1TxAlmFull, and counts write responses until all are back.
module ccip_wr_engine
    import ccip_if_pkg::*;
    import afu_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  t_ccip_clAddr   base_cl_addr,
    input  logic [15:0]    num_lines,
    input  logic [63:0]    seed,
    input  t_if_ccip_Rx    rx,
    output t_if_ccip_c1_Tx tx_c1,
    output logic           busy,
    output logic           done,
    output logic [15:0]    acked
);

    t_wr_state          state_r;
    t_wr_state          state_s;
    t_ccip_clAddr       base_r;
    logic [15:0]        num_r;
    logic [63:0]        seed_r;
    logic [MDATA_W-1:0] idx_r;
    logic [15:0]        acked_r;
    logic               busy_r;
    logic               done_r;
    t_if_ccip_c1_Tx     tx_r;

    logic               issue_s;
    logic               last_s;
    logic               accept_s;
    logic [15:0]        rsp_inc_s;
    t_ccip_c1_ReqMemHdr hdr_s;
    t_ccip_clData       line_s;
    logic               unused_rx_s;

    assign issue_s     = (state_r == ST_ISSUE) && !rx.c1TxAlmFull;
    assign last_s      = issue_s && (idx_r == num_r - 16'd1);
    assign accept_s    = (state_r == ST_IDLE) && start;
    assign unused_rx_s = ^{rx.c0TxAlmFull, rx.c0, rx.c1.hdr};

    ccip_line_gen u_line_gen (
        .seed  (seed_r),
        .index (idx_r),
        .line  (line_s)
    );

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = (num_lines == 16'd0) ? ST_DONE : ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (last_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (acked_r == num_r) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Response credit: single responses count one line, packed ones cl_num+1
    always_comb begin
        rsp_inc_s = 16'd0;
        if (rx.c1.rspValid && (rx.c1.hdr.resp_type == eRSP_WRLINE) &&
            ((state_r == ST_ISSUE) || (state_r == ST_DRAIN))) begin
            if (rx.c1.hdr.format) begin
                rsp_inc_s = {14'd0, rx.c1.hdr.cl_num} + 16'd1;
            end else begin
                rsp_inc_s = 16'd1;
            end
        end else begin
            rsp_inc_s = 16'd0;
        end
    end

    // Request header for the current line index
    always_comb begin
        hdr_s          = '0;
        hdr_s.vc_sel   = eVC_VA;
        hdr_s.sop      = 1'b1;
        hdr_s.mode     = eMOD_CL;
        hdr_s.cl_len   = eCL_LEN_1;
        hdr_s.req_type = eREQ_WRLINE_I;
        hdr_s.address  = base_r + t_ccip_clAddr'(idx_r);
        hdr_s.mdata    = idx_r;
    end

    // State, status flags and burst parameter capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            base_r  <= '0;
            num_r   <= 16'd0;
            seed_r  <= 64'd0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= (state_r == ST_DONE);
            if (accept_s) begin
                base_r <= base_cl_addr;
                num_r  <= num_lines;
                seed_r <= seed;
            end
        end
    end

    // Request channel and line index; header/data hold between requests
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_r  <= '0;
            idx_r <= '0;
        end else begin
            tx_r.valid <= issue_s;
            if (accept_s) begin
                idx_r <= '0;
            end else if (issue_s) begin
                tx_r.hdr  <= hdr_s;
                tx_r.data <= line_s;
                idx_r     <= idx_r + 16'd1;
            end
        end
    end

    // Response counter, cleared only when a new burst is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acked_r <= 16'd0;
        end else if (accept_s) begin
            acked_r <= 16'd0;
        end else begin
            acked_r <= acked_r + rsp_inc_s;
        end
    end

    assign tx_c1 = tx_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign acked = acked_r;

endmodule

// File: tb/tb_ccip_wr_engine.sv
// Self-checking bench for ccip_wr_engine: directed scenarios plus randomized
// bursts checked against a line/header model built from the write rules.
module tb_ccip_wr_engine;
    import ccip_if_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    t_ccip_clAddr   base_cl_addr;
    logic [15:0]    num_lines;
    logic [63:0]    seed;
    t_if_ccip_Rx    rx;
    t_if_ccip_c1_Tx tx_c1;
    logic           busy;
    logic           done;
    logic [15:0]    acked;

    int chk_cnt  = 0;
    int fail_cnt = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int af_viol  = 0;
    logic mon_af;

    typedef struct {
        t_ccip_c1_ReqMemHdr hdr;
        t_ccip_clData       data;
        int                 cyc;
    } obs_t;
    obs_t obs_q[$];

    always #5 clk = ~clk;

    ccip_wr_engine dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_cl_addr (base_cl_addr),
        .num_lines    (num_lines),
        .seed         (seed),
        .rx           (rx),
        .tx_c1        (tx_c1),
        .busy         (busy),
        .done         (done),
        .acked        (acked)
    );

    // Monitor: records issued requests and done pulses after each edge
    always begin
        obs_t o;
        @(posedge clk);
        cyc++;
        mon_af = rx.c1TxAlmFull;
        #2;
        if (!rst) begin
            if (tx_c1.valid) begin
                o.hdr  = tx_c1.hdr;
                o.data = tx_c1.data;
                o.cyc  = cyc;
                obs_q.push_back(o);
                if (mon_af) af_viol++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    function automatic t_ccip_c1_ReqMemHdr exp_hdr(input t_ccip_clAddr b, input int unsigned i);
        t_ccip_c1_ReqMemHdr h;
        h          = '0;
        h.vc_sel   = eVC_VA;
        h.sop      = 1'b1;
        h.mode     = eMOD_CL;
        h.cl_len   = eCL_LEN_1;
        h.req_type = eREQ_WRLINE_I;
        h.address  = b + 42'(i);
        h.mdata    = 16'(i);
        return h;
    endfunction

    function automatic t_ccip_clData exp_line(input logic [63:0] s, input int unsigned i);
        t_ccip_clData d;
        d = '0;
        for (int k = 0; k < 8; k++) d[k*64 +: 64] = s + 64'(i) * 64'd8 + 64'(k);
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input t_ccip_clAddr b, input logic [15:0] n, input logic [63:0] s);
        base_cl_addr = b;
        num_lines    = n;
        seed         = s;
        start        = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_rsp(input logic fmt, input logic [1:0] cln, input t_ccip_c1_rsp typ);
        rx.c1.hdr           = '0;
        rx.c1.hdr.format    = fmt;
        rx.c1.hdr.cl_num    = cln;
        rx.c1.hdr.resp_type = typ;
        rx.c1.rspValid      = 1'b1;
        tick();
        rx.c1.rspValid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        chk_cnt++;
        if (done_cnt == d0) begin
            fail_cnt++;
            $display("FAIL done_timeout: got no done pulse within %0d cycles, required one", budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_cl_addr = '0; num_lines = 16'd0; seed = 64'd0; rx = '0;
        repeat (3) tick();
        chk_cnt++; if (tx_c1.valid !== 1'b0) begin fail_cnt++; $display("FAIL reset_valid: got %0b required 0", tx_c1.valid); end
        chk_cnt++; if (tx_c1.hdr !== '0) begin fail_cnt++; $display("FAIL reset_hdr: got %h required 0", tx_c1.hdr); end
        chk_cnt++; if (tx_c1.data !== '0) begin fail_cnt++; $display("FAIL reset_data: got nonzero %h required 0", tx_c1.data[63:0]); end
        chk_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL reset_busy: got %0b required 0", busy); end
        chk_cnt++; if (done !== 1'b0) begin fail_cnt++; $display("FAIL reset_done: got %0b required 0", done); end
        chk_cnt++; if (acked !== 16'd0) begin fail_cnt++; $display("FAIL reset_acked: got %0d required 0", acked); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int d0;
        logic [63:0] w;
        obs_q.delete();
        d0 = done_cnt;
        start_burst(42'h1000, 16'd4, 64'd0);
        repeat (6) tick();
        chk_cnt++; if (obs_q.size() != 4) begin fail_cnt++; $display("FAIL basic_count: got %0d required 4", obs_q.size()); end
        for (int i = 0; i < obs_q.size(); i++) begin
            chk_cnt++; if (obs_q[i].hdr !== exp_hdr(42'h1000, i)) begin fail_cnt++; $display("FAIL basic_hdr[%0d]: got %h required %h", i, obs_q[i].hdr, exp_hdr(42'h1000, i)); end
            chk_cnt++; if (obs_q[i].data !== exp_line(64'd0, i)) begin fail_cnt++; $display("FAIL basic_data[%0d]: got %h required %h", i, obs_q[i].data, exp_line(64'd0, i)); end
            chk_cnt++; if (obs_q[i].cyc != obs_q[0].cyc + i) begin fail_cnt++; $display("FAIL basic_consec[%0d]: got cycle %0d required %0d", i, obs_q[i].cyc, obs_q[0].cyc + i); end
        end
        w = (obs_q.size() > 1) ? obs_q[1].data[63:0] : '1;
        chk_cnt++; if (w !== 64'd8) begin fail_cnt++; $display("FAIL basic_line1_word0: got %0d required 8", w); end
        chk_cnt++; if (busy !== 1'b1) begin fail_cnt++; $display("FAIL basic_busy_drain: got %0b required 1", busy); end
        repeat (4) send_rsp(1'b0, 2'd0, eRSP_WRLINE);
        wait_done(d0, 20);
        repeat (3) tick();
        chk_cnt++; if (acked !== 16'd4) begin fail_cnt++; $display("FAIL basic_acked: got %0d required 4", acked); end
        chk_cnt++; if (done_cnt != d0 + 1) begin fail_cnt++; $display("FAIL basic_done_once: got %0d pulses required 1", done_cnt - d0); end
        chk_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL basic_busy_idle: got %0b required 0", busy); end
    endtask

    task automatic test_almfull();
        int d0, af0;
        t_ccip_clAddr b;
        logic [63:0] s;
        b = t_ccip_clAddr'({$urandom(), $urandom()});
        s = {$urandom(), $urandom()};
        obs_q.delete();
        d0 = done_cnt; af0 = af_viol;
        start_burst(b, 16'd3, s);
        tick();
        rx.c1TxAlmFull = 1'b1;
        repeat (3) tick();
        rx.c1TxAlmFull = 1'b0;
        tick();
        // response sampled on the same edge that issues the final line
        rx.c1.hdr = '0; rx.c1.hdr.resp_type = eRSP_WRLINE; rx.c1.rspValid = 1'b1;
        tick();
        rx.c1.rspValid = 1'b0;
        repeat (3) tick();
        chk_cnt++; if (obs_q.size() != 3) begin fail_cnt++; $display("FAIL af_count: got %0d required 3", obs_q.size()); end
        chk_cnt++; if (af_viol != af0) begin fail_cnt++; $display("FAIL af_valid_while_full: got %0d violations required 0", af_viol - af0); end
        for (int i = 0; i < obs_q.size(); i++) begin
            chk_cnt++; if (obs_q[i].hdr !== exp_hdr(b, i)) begin fail_cnt++; $display("FAIL af_hdr[%0d]: got %h required %h", i, obs_q[i].hdr, exp_hdr(b, i)); end
            chk_cnt++; if (obs_q[i].data !== exp_line(s, i)) begin fail_cnt++; $display("FAIL af_data[%0d]: got %h required %h", i, obs_q[i].data, exp_line(s, i)); end
        end
        if (obs_q.size() == 3) begin
            chk_cnt++; if (obs_q[1].cyc - obs_q[0].cyc != 4) begin fail_cnt++; $display("FAIL af_gap: got %0d required 4", obs_q[1].cyc - obs_q[0].cyc); end
            chk_cnt++; if (obs_q[2].cyc - obs_q[1].cyc != 1) begin fail_cnt++; $display("FAIL af_resume: got %0d required 1", obs_q[2].cyc - obs_q[1].cyc); end
        end
        repeat (2) send_rsp(1'b0, 2'd0, eRSP_WRLINE);
        wait_done(d0, 20);
        chk_cnt++; if (acked !== 16'd3) begin fail_cnt++; $display("FAIL af_acked: got %0d required 3", acked); end
    endtask

    task automatic test_zero();
        int d0, s0;
        obs_q.delete();
        d0 = done_cnt;
        s0 = cyc;
        start_burst(t_ccip_clAddr'($urandom()), 16'd0, {$urandom(), $urandom()});
        repeat (3) tick();
        chk_cnt++; if (done_cnt != d0 + 1) begin fail_cnt++; $display("FAIL zero_done_once: got %0d pulses required 1", done_cnt - d0); end
        chk_cnt++; if (done_cyc != s0 + 2) begin fail_cnt++; $display("FAIL zero_done_time: got cycle %0d required %0d", done_cyc, s0 + 2); end
        chk_cnt++; if (obs_q.size() != 0) begin fail_cnt++; $display("FAIL zero_no_valid: got %0d required 0", obs_q.size()); end
        chk_cnt++; if (acked !== 16'd0) begin fail_cnt++; $display("FAIL zero_acked: got %0d required 0", acked); end
        chk_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL zero_busy: got %0b required 0", busy); end
    endtask

    task automatic test_packed();
        int d0;
        obs_q.delete();
        d0 = done_cnt;
        start_burst(t_ccip_clAddr'($urandom()), 16'd4, {$urandom(), $urandom()});
        tick();
        send_rsp(1'b1, 2'd1, eRSP_WRLINE);
        send_rsp(1'b0, 2'd0, eRSP_WRFENCE);
        repeat (4) tick();
        chk_cnt++; if (acked !== 16'd2) begin fail_cnt++; $display("FAIL packed_partial: got %0d required 2", acked); end
        send_rsp(1'b0, 2'd0, eRSP_WRLINE);
        send_rsp(1'b0, 2'd0, eRSP_WRLINE);
        wait_done(d0, 20);
        repeat (3) tick();
        chk_cnt++; if (acked !== 16'd4) begin fail_cnt++; $display("FAIL packed_acked: got %0d required 4", acked); end
        chk_cnt++; if (done_cnt != d0 + 1) begin fail_cnt++; $display("FAIL packed_done_once: got %0d pulses required 1", done_cnt - d0); end
        chk_cnt++; if (obs_q.size() != 4) begin fail_cnt++; $display("FAIL packed_count: got %0d required 4", obs_q.size()); end
    endtask

    task automatic test_restart();
        int d0;
        t_ccip_clAddr b;
        logic [63:0] s;
        b = t_ccip_clAddr'($urandom());
        s = {$urandom(), $urandom()};
        obs_q.delete();
        d0 = done_cnt;
        start_burst(b, 16'd3, s);
        start_burst(b + 42'h777, 16'd5, ~s);
        repeat (5) tick();
        chk_cnt++; if (obs_q.size() != 3) begin fail_cnt++; $display("FAIL restart_count: got %0d required 3", obs_q.size()); end
        for (int i = 0; i < obs_q.size(); i++) begin
            chk_cnt++; if (obs_q[i].hdr !== exp_hdr(b, i)) begin fail_cnt++; $display("FAIL restart_hdr[%0d]: got %h required %h", i, obs_q[i].hdr, exp_hdr(b, i)); end
            chk_cnt++; if (obs_q[i].data !== exp_line(s, i)) begin fail_cnt++; $display("FAIL restart_data[%0d]: got %h required %h", i, obs_q[i].data, exp_line(s, i)); end
        end
        repeat (3) send_rsp(1'b0, 2'd0, eRSP_WRLINE);
        wait_done(d0, 20);
        chk_cnt++; if (acked !== 16'd3) begin fail_cnt++; $display("FAIL restart_acked: got %0d required 3", acked); end
    endtask

    task automatic test_reset_mid();
        int d0;
        obs_q.delete();
        d0 = done_cnt;
        start_burst(t_ccip_clAddr'($urandom()), 16'd8, {$urandom(), $urandom()});
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk_cnt++; if (tx_c1.valid !== 1'b0) begin fail_cnt++; $display("FAIL midrst_valid: got %0b required 0", tx_c1.valid); end
        chk_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL midrst_busy: got %0b required 0", busy); end
        chk_cnt++; if (obs_q.size() != 2) begin fail_cnt++; $display("FAIL midrst_issued: got %0d required 2", obs_q.size()); end
        tick();
        tick();
        rst = 1'b0;
        tick();
        repeat (3) send_rsp(1'b0, 2'd0, eRSP_WRLINE);
        repeat (3) tick();
        chk_cnt++; if (acked !== 16'd0) begin fail_cnt++; $display("FAIL midrst_acked: got %0d required 0", acked); end
        chk_cnt++; if (obs_q.size() != 2) begin fail_cnt++; $display("FAIL midrst_no_more_valid: got %0d required 2", obs_q.size()); end
        chk_cnt++; if (done_cnt != d0) begin fail_cnt++; $display("FAIL midrst_no_done: got %0d pulses required 0", done_cnt - d0); end
        chk_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL midrst_idle: got %0b required 0", busy); end
    endtask

    task automatic test_random();
        int n, sent, d0, outstanding, mx, cn, cycles;
        t_ccip_clAddr b;
        logic [63:0] s;
        for (int burst = 0; burst < 6; burst++) begin
            n = $urandom_range(1, 12);
            if (burst % 2 == 1) begin
                b = '1;
                b = b - t_ccip_clAddr'($urandom_range(0, 6));
                s = '1;
                s = s - 64'($urandom_range(0, 40));
            end else begin
                b = t_ccip_clAddr'({$urandom(), $urandom()});
                s = {$urandom(), $urandom()};
            end
            obs_q.delete();
            d0 = done_cnt; sent = 0; cycles = 0;
            start_burst(b, 16'(n), s);
            while (done_cnt == d0 && cycles < 500) begin
                rx.c1TxAlmFull = ($urandom_range(0, 3) == 0);
                rx.c1.rspValid = 1'b0;
                rx.c1.hdr      = '0;
                outstanding    = int'(obs_q.size()) - sent;
                if (outstanding > 0 && $urandom_range(0, 1) == 1) begin
                    rx.c1.rspValid      = 1'b1;
                    rx.c1.hdr.resp_type = eRSP_WRLINE;
                    if (outstanding >= 2 && $urandom_range(0, 2) == 0) begin
                        mx = (outstanding - 1 > 3) ? 3 : outstanding - 1;
                        cn = $urandom_range(1, mx);
                        rx.c1.hdr.format = 1'b1;
                        rx.c1.hdr.cl_num = 2'(cn);
                        sent += cn + 1;
                    end else begin
                        sent += 1;
                    end
                end else if ($urandom_range(0, 5) == 0) begin
                    rx.c1.rspValid      = 1'b1;
                    rx.c1.hdr.resp_type = eRSP_WRFENCE;
                end
                tick();
                cycles++;
                chk_cnt++; if (acked !== 16'(sent)) begin fail_cnt++; $display("FAIL rnd_acked_track: got %0d required %0d", acked, sent); end
            end
            rx.c1TxAlmFull = 1'b0;
            rx.c1.rspValid = 1'b0;
            tick();
            chk_cnt++; if (done_cnt != d0 + 1) begin fail_cnt++; $display("FAIL rnd_done: got %0d pulses required 1 (burst %0d)", done_cnt - d0, burst); end
            chk_cnt++; if (obs_q.size() != n) begin fail_cnt++; $display("FAIL rnd_count: got %0d required %0d", obs_q.size(), n); end
            for (int i = 0; i < obs_q.size(); i++) begin
                chk_cnt++; if (obs_q[i].hdr !== exp_hdr(b, i)) begin fail_cnt++; $display("FAIL rnd_hdr[%0d]: got %h required %h", i, obs_q[i].hdr, exp_hdr(b, i)); end
                chk_cnt++; if (obs_q[i].data !== exp_line(s, i)) begin fail_cnt++; $display("FAIL rnd_data[%0d]: got %h required %h", i, obs_q[i].data, exp_line(s, i)); end
            end
            chk_cnt++; if (acked !== 16'(n)) begin fail_cnt++; $display("FAIL rnd_acked: got %0d required %0d", acked, n); end
        end
        chk_cnt++; if (af_viol != 0) begin fail_cnt++; $display("FAIL rnd_valid_while_full: got %0d violations required 0", af_viol); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_almfull();
        test_zero();
        test_packed();
        test_restart();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
        $finish;
    end

endmodule
